// File: rtl/sram_pixel_writer.sv
// Write-side client of the 1M x 16 SRAM framebuffer: queues pixel requests and
// writes them in granted bus slots. Define PIXWR_CLIP_EN to drop off-screen pixels.
module sram_pixel_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        slot,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [9:0]  px_x,
    input  logic [8:0]  px_y,
    input  logic [5:0]  px_red,
    input  logic [5:0]  px_green,
    input  logic [5:0]  px_blue,
    output logic        busy,
    output logic [15:0] wr_count,
`ifdef PIXWR_CLIP_EN
    output logic [15:0] clip_count,
`endif
    output logic        bus_own,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] H_LIM    = H_RES;
    localparam logic [31:0] V_LIM    = V_RES;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

`ifdef PIXWR_CLIP_EN
    localparam logic CLIP_ON = 1'b1;
`else
    localparam logic CLIP_ON = 1'b0;
`endif

    typedef struct packed {
        logic        clip;
        logic [19:0] addr;
        logic [15:0] data;
    } entry_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        push_entry;
    entry_t        head_entry;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push, pop, write_done;
    logic [1:0]    state_reg, state_next;
    logic [19:0]   addr_reg;
    logic [15:0]   data_reg;
    logic          ce_n_reg, we_n_reg;
    logic [15:0]   wr_count_reg;

    // RGB565 keeps only the top five bits of red and blue
    logic unused_colour_lsbs;
    assign unused_colour_lsbs = px_red[0] ^ px_blue[0];

    assign px_ready = (count_reg != FULL_CNT);
    assign push     = px_valid && px_ready;

    always_comb begin
        push_entry.clip = CLIP_ON && (({22'd0, px_x} >= H_LIM) || ({23'd0, px_y} >= V_LIM));
        push_entry.addr = {1'b0, px_y, px_x};
        push_entry.data = {px_red[5:1], px_green, px_blue[5:1]};
    end

    assign head_entry = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk50) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Clipped entries are popped without leaving IDLE, so they cost no bus cycle
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        write_done = 1'b0;
        if (slot) begin
            case (state_reg)
                ST_IDLE: begin
                    if (count_reg != '0) begin
                        pop = 1'b1;
                        if (!head_entry.clip) begin
                            state_next = ST_SETUP;
                        end
                    end
                end
                ST_SETUP:   state_next = ST_STROBE;
                ST_STROBE:  state_next = ST_RELEASE;
                ST_RELEASE: begin
                    state_next = ST_IDLE;
                    write_done = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk50) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            data_reg     <= '0;
            ce_n_reg     <= 1'b1;
            we_n_reg     <= 1'b1;
            wr_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
            state_reg <= state_next;
            // Strobes are registered from the next state so the pins never glitch
            ce_n_reg  <= (state_next == ST_IDLE);
            we_n_reg  <= (state_next != ST_STROBE);
            if (pop && !head_entry.clip) begin
                addr_reg <= head_entry.addr;
                data_reg <= head_entry.data;
            end
            if (write_done) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

`ifdef PIXWR_CLIP_EN
    logic [15:0] clip_count_reg;

    always_ff @(posedge clk50) begin
        if (!rst) begin
            clip_count_reg <= '0;
        end else if (pop && head_entry.clip) begin
            clip_count_reg <= clip_count_reg + 16'd1;
        end
    end

    assign clip_count = clip_count_reg;
`endif

    assign busy        = (count_reg != '0) || (state_reg != ST_IDLE);
    assign wr_count    = wr_count_reg;
    assign bus_own     = slot && (state_reg != ST_IDLE);
    assign SRAM_ADDR   = addr_reg;
    assign SRAM_DQ_OUT = data_reg;
    assign SRAM_CE_N   = ce_n_reg;
    assign SRAM_OE_N   = 1'b1;
    assign SRAM_WE_N   = we_n_reg;
    assign SRAM_UB_N   = ce_n_reg;
    assign SRAM_LB_N   = ce_n_reg;
endmodule

// File: tb/tb_sram_pixel_writer.sv
// Bench for sram_pixel_writer: a queue of expected SRAM writes is built from the
// accepted requests and checked against every bus-owned WE_N strobe.
module tb_sram_pixel_writer;
    logic        clk50;
    logic        rst;
    logic        slot;
    logic        px_valid;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [8:0]  px_y;
    logic [5:0]  px_red, px_green, px_blue;
    logic        busy;
    logic [15:0] wr_count;
    logic        bus_own;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
`ifdef PIXWR_CLIP_EN
    logic [15:0] clip_count;
    localparam bit TB_CLIP = 1'b1;
`else
    localparam bit TB_CLIP = 1'b0;
`endif

    sram_pixel_writer dut (
        .clk50      (clk50),
        .rst        (rst),
        .slot       (slot),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_red     (px_red),
        .px_green   (px_green),
        .px_blue    (px_blue),
        .busy       (busy),
        .wr_count   (wr_count),
`ifdef PIXWR_CLIP_EN
        .clip_count (clip_count),
`endif
        .bus_own    (bus_own),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    int          checks;
    int          errors;
    int          slot_mode;  // 0 low, 1 toggle, 2 high, 3 driven by the test
    logic [35:0] exp_q[$];
    logic [19:0] last_addr;
    logic [15:0] last_data;

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    always @(posedge clk50) begin
        #1;
        case (slot_mode)
            0:       slot = 1'b0;
            1:       slot = ~slot;
            2:       slot = 1'b1;
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected write from the pixel rules: 1024-word lines, RGB565 colour
    function automatic logic [35:0] model_write(input int x, input int y, input int r, input int g, input int b);
        int a;
        int d;
        a = y * 1024 + x;
        d = (r / 2) * 2048 + g * 32 + (b / 2);
        return {a[19:0], d[15:0]};
    endfunction

    always @(negedge clk50) begin
        logic [35:0] e;
        if (!slot) begin
            chk("bus_own_gated", {31'd0, bus_own}, 32'd0);
        end
        if (bus_own && !SRAM_WE_N) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%05h required no write", SRAM_ADDR);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {12'd0, SRAM_ADDR}, {12'd0, e[35:16]});
                chk("write_data", {16'd0, SRAM_DQ_OUT}, {16'd0, e[15:0]});
                chk("write_strobes", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'h4);
                last_addr = SRAM_ADDR;
                last_data = SRAM_DQ_OUT;
                $display("write addr=%05h data=%04h wr_count=%0d", SRAM_ADDR, SRAM_DQ_OUT, wr_count);
            end
        end
        if (exp_q.size() != 0) begin
            chk("busy_pending", {31'd0, busy}, 32'd1);
        end
    end

    task automatic send(input int x, input int y, input int r, input int g, input int b);
        logic ok;
        ok = 1'b0;
        px_x = 10'(x);
        px_y = 9'(y);
        px_red = 6'(r);
        px_green = 6'(g);
        px_blue = 6'(b);
        px_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            ok = px_ready;
            @(posedge clk50);
            #1;
        end
        px_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not accepted required=accepted x=%0d y=%0d", x, y);
        end else begin
            $display("accept x=%0d y=%0d rgb=(%0d,%0d,%0d)", x, y, r, g, b);
            if (!(TB_CLIP && (x >= 640 || y >= 480))) begin
                exp_q.push_back(model_write(x, y, r, g, b));
            end
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(posedge clk50);
            #1;
            done = !busy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        px_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk50);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic found;
        checks = 0;
        errors = 0;
        slot_mode = 0;
        slot = 1'b0;
        rst = 1'b0;
        px_valid = 1'b0;
        px_x = '0;
        px_y = '0;
        px_red = '0;
        px_green = '0;
        px_blue = '0;
        last_addr = '0;
        last_data = '0;

        // Reset values
        repeat (2) @(posedge clk50);
        #1;
        chk("rst_px_ready", {31'd0, px_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        chk("rst_bus_own", {31'd0, bus_own}, 32'd0);
        chk("rst_addr", {12'd0, SRAM_ADDR}, 32'd0);
        chk("rst_dq", {16'd0, SRAM_DQ_OUT}, 32'd0);
        chk("rst_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        rst = 1'b1;

        // Single write with slot toggling, latency of three granted cycles
        slot_mode = 1;
        send(5, 3, 63, 0, 63);
        lat = 0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk50);
            #1;
            if (slot) lat++;
            found = bus_own && !SRAM_WE_N;
        end
        chk("single_latency", lat, found ? 32'd3 : 32'hDEAD);
        wait_idle();
        chk("single_addr", {12'd0, last_addr}, 32'h00C05);
        chk("single_data", {16'd0, last_data}, 32'hF81F);
        chk("single_wr_count", {16'd0, wr_count}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // Burst of 10 with slot held low, then drained in order
        do_reset();
        slot_mode = 0;
        repeat (2) @(posedge clk50);
        #1;
        for (int i = 0; i < 8; i++) begin
            send(i * 37 + 1, i * 11 + 2, i * 8, 63 - i * 5, i * 3 + 1);
        end
        chk("burst_ready_full", {31'd0, px_ready}, 32'd0);
        px_valid = 1'b1;
        repeat (4) @(posedge clk50);
        #1;
        chk("burst_ready_held", {31'd0, px_ready}, 32'd0);
        chk("burst_no_write", {16'd0, wr_count}, 32'd0);
        slot_mode = 1;
        send(600, 470, 1, 2, 3);
        send(639, 479, 62, 33, 17);
        wait_idle();
        chk("burst_wr_count", {16'd0, wr_count}, 32'd10);
        chk("burst_queue_empty", exp_q.size(), 32'd0);

        // Reset while strobing with three more entries queued
        do_reset();
        slot_mode = 0;
        repeat (2) @(posedge clk50);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(100 + i, 200 + i, 10, 20, 30);
        end
        slot_mode = 2;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk50);
            #1;
            found = bus_own && !SRAM_WE_N;
        end
        chk("midreset_reached_strobe", {31'd0, found}, 32'd1);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk50);
        #1;
        chk("midreset_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_ready", {31'd0, px_ready}, 32'd1);
        chk("midreset_bus_own", {31'd0, bus_own}, 32'd0);
        rst = 1'b1;
        repeat (40) @(posedge clk50);
        #1;
        chk("midreset_wr_count", {16'd0, wr_count}, 32'd0);
        chk("midreset_idle", {31'd0, busy}, 32'd0);

        // Push on the same edge as the pop of a single queued entry
        do_reset();
        slot_mode = 3;
        slot = 1'b0;
        repeat (2) @(posedge clk50);
        #1;
        send(7, 9, 40, 41, 42);
        slot = 1'b1;
        send(8, 9, 2, 4, 6);
        chk("samedge_popped", {31'd0, bus_own}, 32'd1);
        wait_idle();
        chk("samedge_wr_count", {16'd0, wr_count}, 32'd2);
        chk("samedge_last_addr", {12'd0, last_addr}, 32'h02408);
        chk("samedge_last_data", {16'd0, last_data}, 32'h0883);

        // Off-screen request followed by the bottom-right pixel
        do_reset();
        slot_mode = 1;
        send(640, 0, 10, 20, 30);
        send(639, 479, 10, 20, 30);
        wait_idle();
        chk("clip_last_addr", {12'd0, last_addr}, 32'h77E7F);
        chk("clip_last_data", {16'd0, last_data}, 32'h2A8F);
`ifdef PIXWR_CLIP_EN
        chk("clip_count", {16'd0, clip_count}, 32'd1);
        chk("clip_wr_count", {16'd0, wr_count}, 32'd1);
`else
        chk("noclip_wr_count", {16'd0, wr_count}, 32'd2);
`endif
        chk("clip_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
